clk_mon: RTL and testbench

CLK_MON -- requirements
Module: clk_mon

---
 rtl/clk_mon_pkg.sv | 23 ++
 rtl/clk_mon_ch.sv | 100 ++++++++++
 rtl/clk_mon.sv | 138 +++++++++++++
 tb/tb_clk_mon.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_mon_pkg.sv
// Shared types and default sizing for the clock monitor.
package clk_mon_pkg;

    localparam int NCH_DEFAULT  = 4;
    localparam int CW_DEFAULT   = 16;
    localparam int SYNC_DEFAULT = 2;

    // Measurement sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEAS,
        ST_FIN
    } state_e;

    // Per-channel edge tracker states.
    typedef enum logic [1:0] {
        TRK_WAIT1,
        TRK_WAIT2,
        TRK_GOT
    } trk_e;

endpackage

// File: rtl/clk_mon_ch.sv
// One monitored channel: synchronizer, rising-edge detector, first/second
// edge tracker and the result registers that are published at FIN.
module clk_mon_ch
    import clk_mon_pkg::*;
#(
    parameter int CW   = CW_DEFAULT,
    parameter int SYNC = SYNC_DEFAULT
) (
    input  logic          mclk_i,
    input  logic          rst_n_i,
    input  logic          sig_i,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic          fin_i,
    input  logic [CW-1:0] t_i,
    output logic          edge_o,
    output logic          got_o,
    output logic [CW-1:0] per_lat_o,
    output logic [CW-1:0] period_o,
    output logic [CW-1:0] phase_o,
    output logic          timeout_o
);

    logic [SYNC-1:0] sync_q;
    logic            prev_q;
    logic            edge_w;

    trk_e            trk_q, trk_d;
    logic [CW-1:0]   ph_q, ph_d;
    logic [CW-1:0]   per_q, per_d;

    // Bring the asynchronous clock into mclk and keep the previous sample.
    always_ff @(posedge mclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC-2:0], sig_i};
            prev_q <= sync_q[SYNC-1];
        end
    end

    assign edge_w = sync_q[SYNC-1] & ~prev_q;
    assign edge_o = edge_w;

    // Tracker next state: first edge latches phase, second edge latches period.
    always_comb begin
        trk_d = trk_q;
        ph_d  = ph_q;
        per_d = per_q;
        if (clr_i) begin
            trk_d = TRK_WAIT1;
            ph_d  = '0;
            per_d = '0;
        end else if (en_i && edge_w) begin
            case (trk_q)
                TRK_WAIT1: begin
                    ph_d  = t_i;
                    trk_d = TRK_WAIT2;
                end
                TRK_WAIT2: begin
                    // t only grows during a measurement, so this never underflows.
                    per_d = t_i - ph_q;
                    trk_d = TRK_GOT;
                end
                default: ;
            endcase
        end
    end

    // Tracker state register.
    always_ff @(posedge mclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            trk_q <= TRK_WAIT1;
            ph_q  <= '0;
            per_q <= '0;
        end else begin
            trk_q <= trk_d;
            ph_q  <= ph_d;
            per_q <= per_d;
        end
    end

    assign got_o     = (trk_q == TRK_GOT);
    assign per_lat_o = per_q;

    // Publish results only at FIN; an incomplete channel reports zeros and timeout.
    always_ff @(posedge mclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            period_o  <= '0;
            phase_o   <= '0;
            timeout_o <= 1'b0;
        end else if (fin_i) begin
            period_o  <= got_o ? per_q : '0;
            phase_o   <= got_o ? ph_q  : '0;
            timeout_o <= ~got_o;
        end
    end

endmodule

// File: rtl/clk_mon.sv
// Multi-channel clock monitor: measures period of every channel and phase
// relative to channel 0, in mclk cycles, on request.
module clk_mon
    import clk_mon_pkg::*;
#(
    parameter int NCH  = NCH_DEFAULT,
    parameter int CW   = CW_DEFAULT,
    parameter int SYNC = SYNC_DEFAULT
) (
    input  logic              mclk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NCH-1:0]    sig_in,
    output logic              busy,
    output logic              done,
    output logic [NCH*CW-1:0] period,
    output logic [NCH*CW-1:0] phase,
    output logic [NCH-1:0]    mismatch,
    output logic [NCH-1:0]    timeout
);

    localparam logic [CW-1:0] T_MAX = '1;
    localparam logic [CW-1:0] T_ONE = {{(CW-1){1'b0}}, 1'b1};

    state_e          state_q, state_d;
    logic [CW-1:0]   t_q, t_d;
    logic [CW-1:0]   t_trk_w;
    logic            clr_w, trk_en_w, fin_w;
    logic            done_q;
    logic [NCH-1:0]  mismatch_q, mismatch_d;

    logic [NCH-1:0]  edge_w;
    logic [NCH-1:0]  got_w;
    logic [CW-1:0]   per_lat_w [NCH];
    logic            all_got_w;

    // Only channel 0's edge steers the sequencer; the others are tracked locally.
    logic            edge_unused;
    assign edge_unused = ^edge_w[NCH-1:1];

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        clk_mon_ch #(
            .CW   (CW),
            .SYNC (SYNC)
        ) u_ch (
            .mclk_i    (mclk),
            .rst_n_i   (rst_n),
            .sig_i     (sig_in[gi]),
            .clr_i     (clr_w),
            .en_i      (trk_en_w),
            .fin_i     (fin_w),
            .t_i       (t_trk_w),
            .edge_o    (edge_w[gi]),
            .got_o     (got_w[gi]),
            .per_lat_o (per_lat_w[gi]),
            .period_o  (period[gi*CW +: CW]),
            .phase_o   (phase[gi*CW +: CW]),
            .timeout_o (timeout[gi])
        );
    end

    assign all_got_w = &got_w;

    // Sequencer next state, timebase and tracker controls.
    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        t_trk_w  = t_q;
        clr_w    = 1'b0;
        trk_en_w = 1'b0;
        fin_w    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ARM;
                    t_d     = '0;
                    clr_w   = 1'b1;
                end
            end
            ST_ARM: begin
                if (edge_w[0]) begin
                    // This cycle is t=0 for every tracker, channel 0 included.
                    trk_en_w = 1'b1;
                    t_trk_w  = '0;
                    t_d      = T_ONE;
                    state_d  = ST_MEAS;
                end else if (t_q == T_MAX) begin
                    state_d = ST_FIN;
                end else begin
                    t_d = t_q + T_ONE;
                end
            end
            ST_MEAS: begin
                trk_en_w = 1'b1;
                if (all_got_w || (t_q == T_MAX)) begin
                    state_d = ST_FIN;
                end else begin
                    t_d = t_q + T_ONE;
                end
            end
            ST_FIN: begin
                fin_w   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Period comparison against channel 0; incomplete channels never flag.
    always_comb begin
        mismatch_d = '0;
        for (int i = 1; i < NCH; i++) begin
            mismatch_d[i] = got_w[i] && (per_lat_w[i] != per_lat_w[0]);
        end
    end

    // Sequencer registers, done pulse and published mismatch flags.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            t_q        <= '0;
            done_q     <= 1'b0;
            mismatch_q <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            done_q  <= fin_w;
            if (fin_w) begin
                mismatch_q <= mismatch_d;
            end
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign mismatch = mismatch_q;

endmodule

// File: tb/tb_clk_mon.sv
// Bench for clk_mon: directed and randomized channel waveforms, results
// predicted from the waveform parameters.
module tb_clk_mon;

    localparam int NCH = 4;
    localparam int CW  = 16;
    localparam int CW8 = 8;

    logic                mclk = 1'b0;
    logic                rst_n;
    logic                start16, start8;
    logic [NCH-1:0]      sig_in = '0;
    logic                busy16, done16, busy8, done8;
    logic [NCH*CW-1:0]   period16, phase16;
    logic [NCH*CW8-1:0]  period8, phase8;
    logic [NCH-1:0]      mm16, to16, mm8, to8;

    int n_assert = 0;
    int n_fail   = 0;

    bit     cfg_en  [NCH];
    int     cfg_per [NCH];
    int     cfg_dly [NCH];
    bit     gen_en  [NCH];
    int     gen_per [NCH];
    int     gen_dly [NCH];
    longint gen_s = 0;

    logic [63:0] prev_p  [2];
    logic [63:0] prev_ph [2];
    logic [3:0]  prev_mm [2];
    logic [3:0]  prev_to [2];

    clk_mon #(.NCH(NCH), .CW(CW), .SYNC(2)) u_dut16 (
        .mclk     (mclk),
        .rst_n    (rst_n),
        .start    (start16),
        .sig_in   (sig_in),
        .busy     (busy16),
        .done     (done16),
        .period   (period16),
        .phase    (phase16),
        .mismatch (mm16),
        .timeout  (to16)
    );

    clk_mon #(.NCH(NCH), .CW(CW8), .SYNC(2)) u_dut8 (
        .mclk     (mclk),
        .rst_n    (rst_n),
        .start    (start8),
        .sig_in   (sig_in),
        .busy     (busy8),
        .done     (done8),
        .period   (period8),
        .phase    (phase8),
        .mismatch (mm8),
        .timeout  (to8)
    );

    always #5 mclk = ~mclk;

    // Monitored clocks: channel i rises at gen_s + dly + k*per, 50% duty.
    // All edges land on times that are 2 or 7 mod 10, never on an mclk edge.
    always begin : gen_blk
        longint now;
        #1;
        now = longint'($time);
        for (int i = 0; i < NCH; i++) begin
            if (gen_en[i] && (now >= gen_s + gen_dly[i]))
                sig_in[i] = (((now - gen_s - gen_dly[i]) % gen_per[i]) < (gen_per[i] / 2));
            else
                sig_in[i] = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] obs_p(input bit use8);
        return use8 ? {32'b0, period8} : period16;
    endfunction
    function automatic logic [63:0] obs_ph(input bit use8);
        return use8 ? {32'b0, phase8} : phase16;
    endfunction
    function automatic logic [3:0] obs_mm(input bit use8);
        return use8 ? mm8 : mm16;
    endfunction
    function automatic logic [3:0] obs_to(input bit use8);
        return use8 ? to8 : to16;
    endfunction
    function automatic logic obs_busy(input bit use8);
        return use8 ? busy8 : busy16;
    endfunction
    function automatic logic obs_done(input bit use8);
        return use8 ? done8 : done16;
    endfunction

    task automatic set_cfg(input int p0, input int p1, input int p2, input int p3,
                           input int d1, input int d2, input int d3, input bit [3:0] en);
        cfg_per[0] = p0; cfg_per[1] = p1; cfg_per[2] = p2; cfg_per[3] = p3;
        cfg_dly[0] = 0;  cfg_dly[1] = d1; cfg_dly[2] = d2; cfg_dly[3] = d3;
        for (int i = 0; i < NCH; i++) cfg_en[i] = en[i];
    endtask

    task automatic rand_cfg(input bit allow_off);
        cfg_dly[0] = 0;
        for (int i = 0; i < NCH; i++) begin
            cfg_per[i] = int'($urandom_range(20, 4)) * 10;
            if (i > 0) cfg_dly[i] = int'($urandom_range(15, 0)) * 10;
            cfg_en[i] = allow_off ? ($urandom_range(4, 0) != 0) : 1'b1;
        end
    endtask

    // Expected results: ch0's first edge is t=0, channel i's first edge is
    // dly/10 cycles later and its second one per/10 cycles after that.
    function automatic void model(input int cw, output logic [63:0] ep, output logic [63:0] eph,
                                  output logic [3:0] emm, output logic [3:0] eto);
        longint tmax, a, p;
        longint pv [NCH];
        tmax = (longint'(1) << cw) - 1;
        ep = '0; eph = '0; emm = '0; eto = '0;
        for (int i = 0; i < NCH; i++) begin
            pv[i] = 0;
            a = cfg_dly[i] / 10;
            p = cfg_per[i] / 10;
            if (!cfg_en[0] || !cfg_en[i] || (a + p) > tmax) begin
                eto[i] = 1'b1;
            end else begin
                pv[i] = p;
                ep  = ep  | (64'(p) << (i * cw));
                eph = eph | (64'(a) << (i * cw));
            end
        end
        for (int i = 1; i < NCH; i++) emm[i] = !eto[i] && (pv[i] != pv[0]);
    endfunction

    task automatic launch(input bit use8);
        @(negedge mclk);
        if (use8) start8 = 1'b1; else start16 = 1'b1;
        @(negedge mclk);
        start8  = 1'b0;
        start16 = 1'b0;
        gen_s = longint'($time) + 22;
        for (int i = 0; i < NCH; i++) begin
            gen_per[i] = cfg_per[i];
            gen_dly[i] = cfg_dly[i];
            gen_en[i]  = cfg_en[i];
        end
    endtask

    task automatic measure(input string tag, input bit use8, input int budget, input bit poke);
        logic [63:0] ep, eph;
        logic [3:0]  emm, eto;
        bit          seen, hold_err;
        int          ndone, idx;
        idx = use8 ? 1 : 0;
        model(use8 ? CW8 : CW, ep, eph, emm, eto);
        launch(use8);
        check({tag, "_busy"}, 64'(obs_busy(use8)), 64'd1);
        seen = 1'b0; hold_err = 1'b0; ndone = 0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge mclk);
            if (obs_done(use8)) begin
                seen = 1'b1;
                ndone++;
            end else begin
                if (obs_p(use8) !== prev_p[idx] || obs_ph(use8) !== prev_ph[idx] ||
                    obs_mm(use8) !== prev_mm[idx] || obs_to(use8) !== prev_to[idx])
                    hold_err = 1'b1;
                if (poke) begin
                    if (use8) start8 = obs_busy(use8); else start16 = obs_busy(use8);
                end
            end
        end
        start8  = 1'b0;
        start16 = 1'b0;
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_busy_at_done"}, 64'(obs_busy(use8)), 64'd0);
        check({tag, "_period"}, obs_p(use8), ep);
        check({tag, "_phase"}, obs_ph(use8), eph);
        check({tag, "_mismatch"}, 64'(obs_mm(use8)), 64'(emm));
        check({tag, "_timeout"}, 64'(obs_to(use8)), 64'(eto));
        for (int c = 0; c < 40; c++) begin
            @(negedge mclk);
            if (obs_done(use8)) ndone++;
        end
        check({tag, "_done_count"}, 64'(ndone), 64'd1);
        check({tag, "_held"}, 64'(hold_err), 64'd0);
        prev_p[idx] = ep; prev_ph[idx] = eph; prev_mm[idx] = emm; prev_to[idx] = eto;
        for (int i = 0; i < NCH; i++) gen_en[i] = 1'b0;
    endtask

    initial begin
        int ndone;
        rst_n   = 1'b0;
        start16 = 1'b0;
        start8  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            prev_p[k] = '0; prev_ph[k] = '0; prev_mm[k] = '0; prev_to[k] = '0;
        end
        #1;
        check("rst_busy16", 64'(busy16), 64'd0);
        check("rst_done16", 64'(done16), 64'd0);
        check("rst_period16", period16, 64'd0);
        check("rst_phase16", phase16, 64'd0);
        check("rst_mismatch16", 64'(mm16), 64'd0);
        check("rst_timeout16", 64'(to16), 64'd0);
        check("rst_busy8", 64'(busy8), 64'd0);
        check("rst_timeout8", 64'(to8), 64'd0);
        repeat (3) @(negedge mclk);
        rst_n = 1'b1;
        repeat (3) @(negedge mclk);

        set_cfg(80, 80, 80, 80, 0, 0, 0, 4'b1111);
        measure("aligned", 1'b0, 150, 1'b0);

        set_cfg(80, 80, 80, 80, 20, 70, 0, 4'b1111);
        measure("skewed", 1'b0, 150, 1'b0);

        set_cfg(80, 80, 120, 80, 0, 0, 0, 4'b1111);
        measure("slow_ch2", 1'b0, 150, 1'b0);

        set_cfg(80, 80, 80, 80, 10, 30, 50, 4'b1111);
        measure("start_while_busy", 1'b0, 150, 1'b1);

        for (int r = 0; r < 6; r++) begin
            rand_cfg(1'b0);
            measure($sformatf("rand16_%0d", r), 1'b0, 150, 1'b0);
        end

        set_cfg(80, 80, 80, 80, 0, 0, 0, 4'b1110);
        measure("cw8_ch0_low", 1'b1, 400, 1'b0);

        set_cfg(80, 80, 80, 80, 0, 0, 0, 4'b0111);
        measure("cw8_ch3_low", 1'b1, 400, 1'b0);

        for (int r = 0; r < 4; r++) begin
            rand_cfg(1'b1);
            measure($sformatf("rand8_%0d", r), 1'b1, 400, 1'b0);
        end

        // Abort a measurement with reset partway through.
        set_cfg(80, 80, 80, 80, 20, 40, 60, 4'b1111);
        launch(1'b0);
        repeat (8) @(negedge mclk);
        check("abort_busy_before", 64'(busy16), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy16), 64'd0);
        check("abort_done", 64'(done16), 64'd0);
        check("abort_period16", period16, 64'd0);
        check("abort_phase16", phase16, 64'd0);
        check("abort_mismatch16", 64'(mm16), 64'd0);
        check("abort_timeout16", 64'(to16), 64'd0);
        check("abort_period8", 64'(period8), 64'd0);
        check("abort_timeout8", 64'(to8), 64'd0);
        @(negedge mclk);
        rst_n = 1'b1;
        for (int i = 0; i < NCH; i++) gen_en[i] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            prev_p[k] = '0; prev_ph[k] = '0; prev_mm[k] = '0; prev_to[k] = '0;
        end
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge mclk);
            if (done16) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);

        set_cfg(80, 80, 120, 80, 20, 70, 0, 4'b1111);
        measure("after_abort", 1'b0, 150, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
